// File: rtl/activation_pkg.sv
// Shared types and default widths for the activation-unit protocol initiator.
package activation_pkg;

    localparam int ARGW = 16;
    localparam int RESW = 8;
    localparam int ERRW = 16;
    localparam int FBKW = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARG,
        RES,
        DST,
        DLT,
        ERR,
        FBK,
        GRD
    } state_t;

endpackage

// File: rtl/activation_timeout.sv
// Saturating wait-cycle counter: clr restarts it, en advances it, expire flags the last cycle.
// Only built when ACTIVATION_MASTER_TIMEOUT_EN is defined.
`ifdef ACTIVATION_MASTER_TIMEOUT_EN
module activation_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count N-1 is the N-th cycle spent waiting in the current state.
    assign expire_o = en_i && (count_q == LAST);

endmodule
`endif

// File: rtl/activation_master.sv
// Activation-unit initiator: forward pass arg/res, optional training pass err/fbk.
// Optional wait-cycle abort enabled by macro ACTIVATION_MASTER_TIMEOUT_EN.
module activation_master
    import activation_pkg::*;
#(
    parameter int ARGW = activation_pkg::ARGW,
    parameter int RESW = activation_pkg::RESW,
    parameter int ERRW = activation_pkg::ERRW,
    parameter int FBKW = activation_pkg::FBKW
`ifdef ACTIVATION_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [ARGW-1:0] src_data,
    input  logic            src_valid,
    output logic            src_ready,
    output logic [RESW-1:0] dst_data,
    output logic            dst_valid,
    input  logic            dst_ready,
    input  logic [ERRW-1:0] dlt_data,
    input  logic            dlt_valid,
    output logic            dlt_ready,
    output logic [FBKW-1:0] grd_data,
    output logic            grd_valid,
    input  logic            grd_ready,
    output logic [ARGW-1:0] arg_data,
    output logic            arg_valid,
    input  logic            arg_ready,
    input  logic [RESW-1:0] res_data,
    input  logic            res_valid,
    output logic            res_ready,
    output logic [ERRW-1:0] err_data,
    output logic            err_valid,
    input  logic            err_ready,
    input  logic [FBKW-1:0] fbk_data,
    input  logic            fbk_valid,
    output logic            fbk_ready,
    output logic            act_en
`ifdef ACTIVATION_MASTER_TIMEOUT_EN
    ,
    output logic            timeout
`endif
);

    state_t          state_q, state_d;
    logic            en_q, en_d;
    logic [ARGW-1:0] arg_q, arg_d;
    logic [RESW-1:0] res_q, res_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [FBKW-1:0] fbk_q, fbk_d;

`ifdef ACTIVATION_MASTER_TIMEOUT_EN
    logic timed_state;
    logic expire;
    logic abort;

    assign timed_state = (state_q == ARG) || (state_q == RES) ||
                         (state_q == ERR) || (state_q == FBK);

    activation_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_d != state_q),
        .en_i     (timed_state),
        .expire_o (expire)
    );

    assign timeout = abort;
`endif

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        arg_d   = arg_q;
        res_d   = res_q;
        err_d   = err_q;
        fbk_d   = fbk_q;
`ifdef ACTIVATION_MASTER_TIMEOUT_EN
        abort   = 1'b0;
`endif
        case (state_q)
            IDLE: if (src_valid && src_ready) begin
                arg_d   = src_data;
                en_d    = en;
                state_d = ARG;
            end
            ARG: if (arg_valid && arg_ready) state_d = RES;
            RES: if (res_valid && res_ready) begin
                res_d   = res_data;
                state_d = DST;
            end
            DST: if (dst_valid && dst_ready) state_d = en_q ? DLT : IDLE;
            DLT: if (dlt_valid && dlt_ready) begin
                err_d   = dlt_data;
                state_d = ERR;
            end
            ERR: if (err_valid && err_ready) state_d = FBK;
            FBK: if (fbk_valid && fbk_ready) begin
                fbk_d   = fbk_data;
                state_d = GRD;
            end
            GRD: if (grd_valid && grd_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef ACTIVATION_MASTER_TIMEOUT_EN
        // A handshake landing on the expiry cycle wins; only a stalled state is abandoned.
        if (expire && (state_d == state_q)) begin
            abort   = 1'b1;
            state_d = IDLE;
        end
`endif
    end

    // Handshake outputs are decoded from the next state so they are glitch-free registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            arg_q     <= '0;
            res_q     <= '0;
            err_q     <= '0;
            fbk_q     <= '0;
            src_ready <= 1'b0;
            arg_valid <= 1'b0;
            res_ready <= 1'b0;
            dst_valid <= 1'b0;
            dlt_ready <= 1'b0;
            err_valid <= 1'b0;
            fbk_ready <= 1'b0;
            grd_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            arg_q     <= arg_d;
            res_q     <= res_d;
            err_q     <= err_d;
            fbk_q     <= fbk_d;
            src_ready <= (state_d == IDLE);
            arg_valid <= (state_d == ARG);
            res_ready <= (state_d == RES);
            dst_valid <= (state_d == DST);
            dlt_ready <= (state_d == DLT);
            err_valid <= (state_d == ERR);
            fbk_ready <= (state_d == FBK);
            grd_valid <= (state_d == GRD);
        end
    end

    assign arg_data = arg_q;
    assign dst_data = res_q;
    assign err_data = err_q;
    assign grd_data = fbk_q;
    assign act_en   = en_q;

endmodule

// File: tb/tb_activation_master.sv
// Directed bench for activation_master; the bench itself plays a heaviside activation unit.
module tb_activation_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic [7:0]  dst_data;
    logic        dst_valid;
    logic        dst_ready;
    logic [15:0] dlt_data;
    logic        dlt_valid;
    logic        dlt_ready;
    logic [15:0] grd_data;
    logic        grd_valid;
    logic        grd_ready;
    logic [15:0] arg_data;
    logic        arg_valid;
    logic        arg_ready;
    logic [7:0]  res_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] err_data;
    logic        err_valid;
    logic        err_ready;
    logic [15:0] fbk_data;
    logic        fbk_valid;
    logic        fbk_ready;
    logic        act_en;
`ifdef ACTIVATION_MASTER_TIMEOUT_EN
    logic        timeout;
`endif

    always #5 clk = ~clk;

    activation_master #(
        .ARGW (16)
`ifdef ACTIVATION_MASTER_TIMEOUT_EN
        ,
        .TIMEOUT (16)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .dst_data  (dst_data),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .dlt_data  (dlt_data),
        .dlt_valid (dlt_valid),
        .dlt_ready (dlt_ready),
        .grd_data  (grd_data),
        .grd_valid (grd_valid),
        .grd_ready (grd_ready),
        .arg_data  (arg_data),
        .arg_valid (arg_valid),
        .arg_ready (arg_ready),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .err_data  (err_data),
        .err_valid (err_valid),
        .err_ready (err_ready),
        .fbk_data  (fbk_data),
        .fbk_valid (fbk_valid),
        .fbk_ready (fbk_ready),
        .act_en    (act_en)
`ifdef ACTIVATION_MASTER_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Activation unit model and event trackers.
    logic        unit_arg_ready;
    logic        unit_hold_res;
    logic        res_pending;
    logic [7:0]  res_val;
    logic        fbk_pending;
    logic [15:0] fbk_val;
    int          dlt_fires;
    logic        saw_dlt_ready, saw_err_valid, saw_grd_valid, saw_dst_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic clear_flags();
        saw_dlt_ready = 1'b0;
        saw_err_valid = 1'b0;
        saw_grd_valid = 1'b0;
        saw_dst_valid = 1'b0;
        dlt_fires     = 0;
    endtask

    task automatic reset_unit();
        res_pending = 1'b0;
        fbk_pending = 1'b0;
        res_valid   = 1'b0;
        fbk_valid   = 1'b0;
        res_data    = 8'h00;
        fbk_data    = 16'h0000;
    endtask

    // One clock: note handshakes due at the edge, then update the unit model after it.
    task automatic step();
        logic        arg_f, res_f, err_f, fbk_f, src_f, dlt_f;
        logic [15:0] arg_s, err_s;
        arg_f = arg_valid && arg_ready;
        res_f = res_valid && res_ready;
        err_f = err_valid && err_ready;
        fbk_f = fbk_valid && fbk_ready;
        src_f = src_valid && src_ready;
        dlt_f = dlt_valid && dlt_ready;
        arg_s = arg_data;
        err_s = err_data;
        @(posedge clk);
        #1;
        if (src_f) src_valid = 1'b0;
        if (dlt_f) begin
            dlt_valid = 1'b0;
            dlt_fires++;
        end
        if (arg_f) begin
            res_pending = 1'b1;
            res_val     = ($signed(arg_s) >= 0) ? 8'hff : 8'h00;
        end
        if (res_f) res_pending = 1'b0;
        if (err_f) begin
            fbk_pending = 1'b1;
            fbk_val     = err_s;
        end
        if (fbk_f) fbk_pending = 1'b0;
        arg_ready = unit_arg_ready;
        res_valid = res_pending && !unit_hold_res;
        res_data  = res_pending ? res_val : 8'h00;
        fbk_valid = fbk_pending;
        fbk_data  = fbk_pending ? fbk_val : 16'h0000;
        if (dlt_ready) saw_dlt_ready = 1'b1;
        if (err_valid) saw_err_valid = 1'b1;
        if (grd_valid) saw_grd_valid = 1'b1;
        if (dst_valid) saw_dst_valid = 1'b1;
    endtask

    // Offer one source value; en is flipped after acceptance to show it is ignored.
    task automatic send(input logic [15:0] d, input logic e);
        src_data  = d;
        src_valid = 1'b1;
        en        = e;
        for (int i = 0; i < 20 && src_valid; i++) step();
        check("src_accept", src_valid, 1'b0);
        en = ~e;
    endtask

    task automatic wait_dst();
        for (int i = 0; i < 20 && !dst_valid; i++) step();
        check("dst_valid_seen", dst_valid, 1'b1);
    endtask

    task automatic take_dst();
        dst_ready = 1'b1;
        step();
        dst_ready = 1'b0;
    endtask

    task automatic wait_err();
        for (int i = 0; i < 20 && !err_valid; i++) step();
        check("err_valid_seen", err_valid, 1'b1);
    endtask

    task automatic wait_grd();
        for (int i = 0; i < 20 && !grd_valid; i++) step();
        check("grd_valid_seen", grd_valid, 1'b1);
    endtask

    task automatic take_grd();
        grd_ready = 1'b1;
        step();
        grd_ready = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst       = 1'b0;
        en        = 1'b0;
        src_data  = '0;
        src_valid = 1'b0;
        dst_ready = 1'b0;
        dlt_data  = '0;
        dlt_valid = 1'b0;
        grd_ready = 1'b0;
        err_ready = 1'b1;
        arg_ready = 1'b1;
        unit_arg_ready = 1'b1;
        unit_hold_res  = 1'b0;
        res_val = '0;
        fbk_val = '0;
        reset_unit();
        clear_flags();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_src_ready", src_ready, 1'b0);
        check("rst_arg_valid", arg_valid, 1'b0);
        check("rst_dst_valid", dst_valid, 1'b0);
        check("rst_grd_valid", grd_valid, 1'b0);
        check("rst_act_en", act_en, 1'b0);
        check("rst_dst_data", dst_data, 8'h00);
        rst = 1'b1;
        check("rel_src_ready_before_edge", src_ready, 1'b0);
        step();
        check("rel_src_ready_after_edge", src_ready, 1'b1);

        // Forward pass, en=0
        clear_flags();
        send(16'h0000, 1'b0);
        check("fwd_act_en", act_en, 1'b0);
        wait_dst();
        check("fwd_dst_data", dst_data, 8'hff);
        take_dst();
        check("fwd_idle_src_ready", src_ready, 1'b1);
        check("fwd_no_dlt_ready", saw_dlt_ready, 1'b0);
        check("fwd_no_err_valid", saw_err_valid, 1'b0);
        check("fwd_no_grd_valid", saw_grd_valid, 1'b0);

        // Training pass, en=1
        clear_flags();
        send(16'hffff, 1'b1);
        check("trn_act_en", act_en, 1'b1);
        wait_dst();
        check("trn_dst_data", dst_data, 8'h00);
        take_dst();
        dlt_data  = 16'hffff;
        dlt_valid = 1'b1;
        wait_err();
        check("trn_err_data", err_data, 16'hffff);
        wait_grd();
        check("trn_grd_data", grd_data, 16'hffff);
        take_grd();
        check("trn_idle_src_ready", src_ready, 1'b1);
        check("trn_dlt_once", dlt_fires, 1);

        // Downstream backpressure
        clear_flags();
        send(16'h0000, 1'b0);
        wait_dst();
        for (int i = 0; i < 10; i++) begin
            check("bp_dst_valid", dst_valid, 1'b1);
            check("bp_dst_data", dst_data, 8'hff);
            check("bp_src_ready", src_ready, 1'b0);
            step();
        end
        take_dst();
        check("bp_idle_src_ready", src_ready, 1'b1);

        // Early error held off until DLT
        clear_flags();
        unit_arg_ready = 1'b0;
        arg_ready      = 1'b0;
        send(16'h0000, 1'b1);
        dlt_data  = 16'h1234;
        dlt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("early_dlt_ready", dlt_ready, 1'b0);
            check("early_arg_valid", arg_valid, 1'b1);
            step();
        end
        unit_arg_ready = 1'b1;
        wait_dst();
        check("early_dst_data", dst_data, 8'hff);
        check("early_dlt_pending", dlt_fires, 0);
        take_dst();
        wait_err();
        check("early_err_data", err_data, 16'h1234);
        check("early_dlt_once", dlt_fires, 1);
        wait_grd();
        check("early_grd_data", grd_data, 16'h1234);
        take_grd();
        repeat (3) step();
        check("early_dlt_still_once", dlt_fires, 1);
        check("early_idle_src_ready", src_ready, 1'b1);

        // Reset mid-transaction in RES
        clear_flags();
        unit_hold_res = 1'b1;
        send(16'h0000, 1'b1);
        for (int i = 0; i < 20 && !res_ready; i++) step();
        check("mid_in_res", res_ready, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_arg_valid", arg_valid, 1'b0);
        check("mid_res_ready", res_ready, 1'b0);
        check("mid_dst_valid", dst_valid, 1'b0);
        check("mid_err_valid", err_valid, 1'b0);
        check("mid_grd_valid", grd_valid, 1'b0);
        check("mid_src_ready", src_ready, 1'b0);
        check("mid_act_en", act_en, 1'b0);
        unit_hold_res = 1'b0;
        reset_unit();
        repeat (2) step();
        rst = 1'b1;
        step();
        check("mid_rel_src_ready", src_ready, 1'b1);
        send(16'h0000, 1'b0);
        wait_dst();
        check("mid_fresh_dst_data", dst_data, 8'hff);
        take_dst();
        check("mid_fresh_idle", src_ready, 1'b1);

`ifdef ACTIVATION_MASTER_TIMEOUT_EN
        // Stalled arg channel aborts after 16 cycles
        clear_flags();
        unit_arg_ready = 1'b0;
        arg_ready      = 1'b0;
        send(16'h0000, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            check("to_pulse_cycle", timeout, (k == 16));
            if (k < 16) step();
        end
        step();
        check("to_idle_src_ready", src_ready, 1'b1);
        check("to_arg_valid_low", arg_valid, 1'b0);
        check("to_pulse_done", timeout, 1'b0);
        check("to_no_dst_valid", saw_dst_valid, 1'b0);
        unit_arg_ready = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
